// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, combinational-read instruction memory and a prefetch FIFO of {instr, pc}.
// One-cycle fetch-to-IR_VALID, 2-cycle redirect penalty; IR_READY low stalls, FIFO fills then PC holds.

module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign do_pop   = pop_rdy & head_vld;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_rdy = ~full | do_pop;
  assign do_push  = push_vld & push_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= (PW+1)'(DEPTH));

endmodule

module instruction_fetch_unit #(
  parameter int          IMEM_DEPTH   = 4096,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PC_write_enable,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        IR_READY,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] IR_PC,
  output logic [31:0] adder_output,
  output logic        FETCH_FAULT,
  input  logic        IMEM_WE,
  input  logic [31:0] IMEM_WADDR,
  input  logic [31:0] IMEM_WDATA
);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam int          AW         = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [31:0] IMEM_WORDS = 32'(IMEM_DEPTH);

  logic [31:0]  imem [IMEM_DEPTH];
  logic [31:0]  pc_q, pc_d;
  logic         fetch_fault_q, fetch_fault_d;
  logic         pc_in_range;
  logic         wr_in_range;
  logic         fetch_req;
  logic         push_vld;
  logic         push_rdy;
  logic         pop_rdy;
  logic         head_vld;
  logic [31:0]  fetch_instr;
  fetch_entry_t push_dat;
  fetch_entry_t head_dat;
  logic         unused_addr_bits;

  assign pc_in_range      = ({2'b00, pc_q[31:2]} < IMEM_WORDS);
  assign wr_in_range      = ({2'b00, IMEM_WADDR[31:2]} < IMEM_WORDS);
  assign unused_addr_bits = ^{BRANCH_TARGET[1:0], IMEM_WADDR[1:0]};

  // Combinational read sees the pre-edge contents, so a same-cycle write returns old data.
  assign fetch_instr = imem[pc_q[AW+1:2]];

  always_ff @(posedge CLK) begin
    if (IMEM_WE && wr_in_range) begin
      imem[IMEM_WADDR[AW+1:2]] <= IMEM_WDATA;
    end
  end

  assign fetch_req = PC_write_enable & ~BRANCH_TAKEN;
  assign push_vld  = fetch_req & ~fetch_fault_q & pc_in_range;
  assign pop_rdy   = IR_READY & ~BRANCH_TAKEN;
  assign push_dat  = {fetch_instr, pc_q};

  always_comb begin
    pc_d          = pc_q;
    fetch_fault_d = fetch_fault_q;
    if (BRANCH_TAKEN) begin
      pc_d          = {BRANCH_TARGET[31:2], 2'b00};
      fetch_fault_d = 1'b0;
    end else begin
      if (push_vld && push_rdy) begin
        pc_d = pc_q + 32'd4;
      end
      if (fetch_req && !pc_in_range) begin
        fetch_fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q          <= RESET_VECTOR;
      fetch_fault_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_prefetch (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .flush    (BRANCH_TAKEN),
    .push_vld (push_vld),
    .push_rdy (push_rdy),
    .push_dat (push_dat),
    .pop_rdy  (pop_rdy),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  assign IR           = head_dat.instr;
  assign IR_PC        = head_dat.pc;
  assign IR_VALID     = head_vld;
  assign FETCH_FAULT  = fetch_fault_q;
  assign adder_output = IR_PC + 32'd4;

  a_pc_aligned: assert property (@(posedge CLK) disable iff (!RESET_N) pc_q[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: scoreboarded streaming phases plus a cycle vector table
// for redirect/fault corners, read-before-write and mid-stream reset.

module tb_instruction_fetch_unit;
  localparam int IMEM_DEPTH = 16;
  localparam int FIFO_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PC_write_enable;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        IR_READY;
  logic [31:0] IR;
  logic        IR_VALID;
  logic [31:0] IR_PC;
  logic [31:0] adder_output;
  logic        FETCH_FAULT;
  logic        IMEM_WE;
  logic [31:0] IMEM_WADDR;
  logic [31:0] IMEM_WDATA;

  instruction_fetch_unit #(
    .IMEM_DEPTH   (IMEM_DEPTH),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .PC_write_enable (PC_write_enable),
    .BRANCH_TAKEN    (BRANCH_TAKEN),
    .BRANCH_TARGET   (BRANCH_TARGET),
    .IR_READY        (IR_READY),
    .IR              (IR),
    .IR_VALID        (IR_VALID),
    .IR_PC           (IR_PC),
    .adder_output    (adder_output),
    .FETCH_FAULT     (FETCH_FAULT),
    .IMEM_WE         (IMEM_WE),
    .IMEM_WADDR      (IMEM_WADDR),
    .IMEM_WDATA      (IMEM_WDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        pwe;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        exp_vld;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[14];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_pops = 0;
  logic sb_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic br, input logic [31:0] tgt, input logic rdy);
    PC_write_enable = pwe;
    BRANCH_TAKEN    = br;
    BRANCH_TARGET   = tgt;
    IR_READY        = rdy;
  endtask

  task automatic sb_load(input int start, input int n);
    exp_t e;
    sb_q.delete();
    for (int i = 0; i < n; i++) begin
      e.ir = 32'h1000_0000 + 32'(start + i);
      e.pc = 32'((start + i) * 4);
      sb_q.push_back(e);
    end
  endtask

  // Sample on the falling edge (handshake scoreboard), then land 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    if (sb_en && RESET_N && IR_VALID && IR_READY && !BRANCH_TAKEN) begin
      n_pops++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underrun: unexpected pop IR_PC=%h IR=%h", IR_PC, IR);
      end else begin
        e = sb_q.pop_front();
        check("sb_ir", IR, e.ir);
        check("sb_pc", IR_PC, e.pc);
        check("sb_adder", adder_output, e.pc + 32'd4);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int guard;

    tbl[0]  = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b0, 32'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h10, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 32'h00, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h3C, 1'b1, 1'b0, 32'h00, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h3C, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'h3F, 1'b0, 1'b0, 32'h00, 1'b0};

    RESET_N    = 1'b0;
    IMEM_WE    = 1'b0;
    IMEM_WADDR = '0;
    IMEM_WDATA = '0;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < IMEM_DEPTH; i++) begin
      IMEM_WE    = 1'b1;
      IMEM_WADDR = 32'(i * 4);
      IMEM_WDATA = 32'h1000_0000 + 32'(i);
      step();
    end
    // Out-of-range write aliases word 0 if the range check is missing.
    IMEM_WADDR = 32'h40;
    IMEM_WDATA = 32'hDEAD_BEEF;
    step();
    IMEM_WE = 1'b0;
    step();

    check1("rst_valid", IR_VALID, 1'b0);
    check("rst_ir", IR, 32'h0);
    check("rst_pc", IR_PC, 32'h0);
    check1("rst_fault", FETCH_FAULT, 1'b0);
    check("rst_adder", adder_output, 32'h4);

    // Streaming from reset with consumer always ready.
    sb_load(0, IMEM_DEPTH);
    sb_en   = 1'b1;
    RESET_N = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check1("first_valid_pre", IR_VALID, 1'b0);
    p0 = n_pops;
    step();
    check1("first_valid", IR_VALID, 1'b1);
    check("first_ir", IR, 32'h1000_0000);
    check("first_pc", IR_PC, 32'h0);
    check("first_adder", adder_output, 32'h4);
    repeat (3) step();
    check("stream_pops", 32'(n_pops - p0), 32'd3);

    // Stall: FIFO saturates, head holds word 3.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check1("stall_valid", IR_VALID, 1'b1);
      check("stall_pc", IR_PC, 32'hC);
    end

    // Full FIFO, one ready cycle: simultaneous pop and push.
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    step();
    check("full_pop_pc", IR_PC, 32'h10);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) step();
    check("full_hold_pc", IR_PC, 32'h10);

    // Fetch disabled: drain exposes the occupancy, which must still be FIFO_DEPTH.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    p0 = n_pops;
    guard = 0;
    do begin
      step();
      guard++;
    end while (IR_VALID && guard < 20);
    check("drain_pops", 32'(n_pops - p0), 32'(FIFO_DEPTH));
    check1("drain_valid", IR_VALID, 1'b0);
    repeat (2) begin
      step();
      check1("empty_valid", IR_VALID, 1'b0);
    end
    check("empty_pops", 32'(n_pops - p0), 32'(FIFO_DEPTH));

    // PC held while disabled: resumes at word 8; buffer three entries.
    sb_en = 1'b0;
    sb_q.delete();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    check("hold_pc", IR_PC, 32'h20);
    check("hold_ir", IR, 32'h1000_0008);
    repeat (2) step();

    foreach (tbl[i]) begin
      drive(tbl[i].pwe, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
      step();
      check1($sformatf("vec%0d_valid", i), IR_VALID, tbl[i].exp_vld);
      check1($sformatf("vec%0d_fault", i), FETCH_FAULT, tbl[i].exp_fault);
      if (tbl[i].exp_vld) begin
        check($sformatf("vec%0d_pc", i), IR_PC, tbl[i].exp_pc);
        check($sformatf("vec%0d_ir", i), IR, 32'h1000_0000 + (tbl[i].exp_pc >> 2));
        check($sformatf("vec%0d_adder", i), adder_output, tbl[i].exp_pc + 32'd4);
      end
    end

    // Read-before-write on the word being fetched.
    drive(1'b1, 1'b1, 32'h20, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    IMEM_WE    = 1'b1;
    IMEM_WADDR = 32'h20;
    IMEM_WDATA = 32'hCAFE_0008;
    step();
    IMEM_WE = 1'b0;
    check("rbw_old_ir", IR, 32'h1000_0008);
    check("rbw_old_pc", IR_PC, 32'h20);
    drive(1'b1, 1'b1, 32'h20, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    check("rbw_new_ir", IR, 32'hCAFE_0008);

    // Reset pulsed between edges while streaming.
    drive(1'b0, 1'b1, 32'h0, 1'b0);
    step();
    sb_load(0, 8);
    sb_en = 1'b1;
    p0 = n_pops;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (4) step();
    check("pre_rst_pops", 32'(n_pops - p0), 32'd3);
    #2;
    RESET_N = 1'b0;
    #1;
    check1("midrst_valid", IR_VALID, 1'b0);
    check("midrst_pc", IR_PC, 32'h0);
    check("midrst_ir", IR, 32'h0);
    sb_en = 1'b0;
    repeat (2) step();

    sb_load(0, 8);
    sb_en   = 1'b1;
    p0      = n_pops;
    RESET_N = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    check1("restart_valid_pre", IR_VALID, 1'b0);
    step();
    check1("restart_valid", IR_VALID, 1'b1);
    check("restart_ir", IR, 32'h1000_0000);
    check("restart_pc", IR_PC, 32'h0);
    repeat (5) step();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    check("restart_pops", 32'(n_pops - p0), 32'd5);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
